// File: rtl/clock_set_sequencer.sv
// clock_set_sequencer: capture/edit/commit sequencer for setting the clock time, with field blink enables (optional 12-hour mode: CLOCK_SET_TWELVE_HOUR_EN).
module clock_set_sequencer #(
  parameter int BLINK_DIV = 25000000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_ena,
  input  logic       i_wr_toggle,
  input  logic [1:0] i_sel_val,
  input  logic       i_up_pulse,
  input  logic       i_down_pulse,
  input  logic [4:0] i_cur_hh,
  input  logic [5:0] i_cur_mm,
  input  logic [5:0] i_cur_ss,
  output logic [4:0] o_set_hh,
  output logic [5:0] o_set_mm,
  output logic [5:0] o_set_ss,
  output logic       o_load,
  output logic       o_hold,
  output logic [2:0] o_blink_mask,
`ifdef CLOCK_SET_TWELVE_HOUR_EN
  output logic       o_pm,
`endif
  output logic       o_busy
);
  localparam int CW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLINK_DIV - 1);
`ifdef CLOCK_SET_TWELVE_HOUR_EN
  localparam logic [4:0] HLO = 5'd1;
  localparam logic [4:0] HHI = 5'd12;
`else
  localparam logic [4:0] HLO = 5'd0;
  localparam logic [4:0] HHI = 5'd23;
`endif
  typedef enum logic [1:0] {RUN, CAPTURE, EDIT, COMMIT} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic phase;
  logic [4:0] sh_hh, hh_n;
  logic [5:0] sh_mm, sh_ss, mm_n, ss_n;
  logic up, dn, hu, hd;
  function automatic logic [5:0] bump(input logic [5:0] v, input logic u, input logic d);
    return u ? (v >= 6'd59 ? 6'd0 : v + 6'd1) : d ? (v == 6'd0 ? 6'd59 : v - 6'd1) : v;
  endfunction
  // Simultaneous up and down cancel each other
  assign up = i_up_pulse & ~i_down_pulse;
  assign dn = i_down_pulse & ~i_up_pulse;
  assign hu = up && i_sel_val == 2'd2;
  assign hd = dn && i_sel_val == 2'd2;
  assign ss_n = bump(sh_ss, up && i_sel_val == 2'd0, dn && i_sel_val == 2'd0);
  assign mm_n = bump(sh_mm, up && i_sel_val == 2'd1, dn && i_sel_val == 2'd1);
  assign hh_n = hu ? (sh_hh >= HHI ? HLO : sh_hh + 5'd1) : hd ? (sh_hh <= HLO ? HHI : sh_hh - 5'd1) : sh_hh;
  assign o_set_mm = sh_mm;
  assign o_set_ss = sh_ss;
  assign o_hold = state != RUN;
  assign o_busy = state != RUN;
  assign o_load = state == COMMIT && i_ena;
  assign o_blink_mask = (state == EDIT && i_sel_val != 2'd3) ? {2'b00, phase} << i_sel_val : 3'b000;
`ifdef CLOCK_SET_TWELVE_HOUR_EN
  logic [4:0] cap_hh;
  assign cap_hh = i_cur_hh == 5'd0 ? 5'd12 : i_cur_hh > 5'd12 ? i_cur_hh - 5'd12 : i_cur_hh;
  // The timekeeper always receives 24-hour time at commit
  assign o_set_hh = state != COMMIT ? sh_hh :
                    o_pm ? (sh_hh == 5'd12 ? 5'd12 : sh_hh + 5'd12) : (sh_hh == 5'd12 ? 5'd0 : sh_hh);
`else
  assign o_set_hh = sh_hh;
`endif
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= RUN;
      sh_hh <= '0;
      sh_mm <= '0;
      sh_ss <= '0;
      cnt <= '0;
      phase <= 1'b0;
`ifdef CLOCK_SET_TWELVE_HOUR_EN
      o_pm <= 1'b0;
`endif
    end else if (i_ena) begin
      cnt <= cnt == LAST ? '0 : cnt + 1'b1;
      if (cnt == LAST) phase <= ~phase;
      case (state)
        RUN: if (i_wr_toggle) state <= CAPTURE;
        CAPTURE: begin
          state <= EDIT;
          sh_mm <= i_cur_mm;
          sh_ss <= i_cur_ss;
`ifdef CLOCK_SET_TWELVE_HOUR_EN
          sh_hh <= cap_hh;
          o_pm <= i_cur_hh >= 5'd12;
`else
          sh_hh <= i_cur_hh;
`endif
        end
        EDIT: begin
          if (!i_wr_toggle) state <= COMMIT;
          else begin
            sh_ss <= ss_n;
            sh_mm <= mm_n;
            sh_hh <= hh_n;
`ifdef CLOCK_SET_TWELVE_HOUR_EN
            if ((hu && sh_hh == 5'd11) || (hd && sh_hh == 5'd12)) o_pm <= ~o_pm;
`endif
          end
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_clock_set_sequencer.sv
// tb_clock_set_sequencer: directed plus random stimulus checked against an arithmetic reference model.
module tb_clock_set_sequencer;
  logic clk = 1'b0, rst, ena, tog, up, dn;
  logic [1:0] sel;
  logic [4:0] cur_hh, set_hh;
  logic [5:0] cur_mm, cur_ss, set_mm, set_ss;
  logic load, hold, busy;
  logic [2:0] mask;
`ifdef CLOCK_SET_TWELVE_HOUR_EN
  logic pm;
`endif
  int cmp = 0, errs = 0;
  int mode = 0, mh = 0, mm = 0, ms = 0, ticks = 0;
  always #5 clk = ~clk;
  clock_set_sequencer #(.BLINK_DIV(4)) dut (
    .i_clk(clk), .i_reset(rst), .i_ena(ena), .i_wr_toggle(tog), .i_sel_val(sel),
    .i_up_pulse(up), .i_down_pulse(dn), .i_cur_hh(cur_hh), .i_cur_mm(cur_mm), .i_cur_ss(cur_ss),
    .o_set_hh(set_hh), .o_set_mm(set_mm), .o_set_ss(set_ss), .o_load(load), .o_hold(hold),
    .o_blink_mask(mask),
`ifdef CLOCK_SET_TWELVE_HOUR_EN
    .o_pm(pm),
`endif
    .o_busy(busy)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask
  // mode: 0 idle, 1 capturing, 2 editing, 3 committing
  task automatic step(input logic r, input logic e, input logic t, input logic [1:0] s, input logic u, input logic d);
    rst = r; ena = e; tog = t; sel = s; up = u; dn = d;
    @(posedge clk);
    if (r) begin
      mode = 0; mh = 0; mm = 0; ms = 0; ticks = 0;
    end else if (e) begin
      ticks++;
      if (mode == 0) mode = t ? 1 : 0;
      else if (mode == 1) begin
        mh = cur_hh; mm = cur_mm; ms = cur_ss; mode = 2;
      end else if (mode == 2) begin
        if (!t) mode = 3;
        else if (u != d) begin
          if (s == 0) ms = (ms + (u ? 1 : 59)) % 60;
          if (s == 1) mm = (mm + (u ? 1 : 59)) % 60;
          if (s == 2) mh = (mh + (u ? 1 : 23)) % 24;
        end
      end else mode = 0;
    end
    #1;
    chk("hold", hold, mode != 0);
    chk("busy", busy, mode != 0);
    chk("load", load, mode == 3 && e);
    chk("mask", mask, (mode == 2 && s != 3) ? ((ticks / 4) % 2) << s : 0);
    chk("set_hh", set_hh, mh);
    chk("set_mm", set_mm, mm);
    chk("set_ss", set_ss, ms);
  endtask
  initial begin
    cur_hh = 10; cur_mm = 20; cur_ss = 30;
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    chk("reset_mask", mask, 0);
    step(0, 1, 0, 3, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    chk("capture_hold", hold, 1);
    step(0, 1, 1, 0, 0, 0);
    chk("edit_ss", set_ss, 30);
    step(0, 1, 0, 0, 1, 0);
    chk("commit_load", load, 1);
    chk("commit_hh", set_hh, 10);
    step(0, 1, 0, 0, 0, 0);
    chk("after_busy", busy, 0);
    chk("after_load", load, 0);
    cur_hh = 0; cur_mm = 0; cur_ss = 59;
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 1, 0);
    chk("ss_wrap", set_ss, 0);
    chk("ss_nocarry", set_mm, 0);
    step(0, 1, 1, 2, 0, 1);
    chk("hh_wrap", set_hh, 23);
    step(0, 1, 1, 1, 0, 1);
    chk("mm_wrap", set_mm, 59);
    step(0, 1, 1, 1, 1, 1);
    chk("updn_nochange", set_mm, 59);
    step(0, 1, 1, 3, 1, 0);
    chk("sel3_mask", mask, 0);
    chk("sel3_ss", set_ss, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 1, 2, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 2, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 2, 0, 0);
    step(0, 1, 0, 2, 1, 0);
    step(0, 0, 0, 2, 0, 0);
    chk("frozen_commit_load", load, 0);
    step(0, 0, 0, 2, 0, 0);
    step(0, 1, 0, 2, 0, 0);
    step(0, 1, 0, 2, 0, 0);
    cur_hh = 12; cur_mm = 34; cur_ss = 56;
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    chk("mid_edit_hh", set_hh, 12);
    step(1, 1, 1, 0, 1, 0);
    chk("reset_mid_hold", hold, 0);
    chk("reset_mid_ss", set_ss, 0);
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      logic t;
      cur_hh = 5'($urandom_range(0, 23));
      cur_mm = 6'($urandom_range(0, 59));
      cur_ss = 6'($urandom_range(0, 59));
      t = ($urandom_range(0, 7) == 0) ? ~tog : tog;
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0, t, 2'($urandom_range(0, 3)),
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
